noc_vc_rx_buffer: RTL and testbench

Parametrised multi-virtual-channel receive buffer for NoC clients and routers. It accepts flits (data, last, addr) tagged with a one-hot VC and stores each VC in its own FIFO. It exports per-VC backpressure and occupancy counts, and drains the FIFOs to a single registered output port. A packet-atomic round-robin arbiter selects which VC drains, so flits of different packets never interleave on the output.

---
 rtl/noc_vc_rx_buffer.sv | 143 ++++++++++++++
 tb/tb_noc_vc_rx_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_rx_buffer.sv
// rtl/noc_vc_rx_buffer.sv - multi-VC receive buffer with packet-atomic round-robin drain
// Per-VC FIFOs feed one registered output flit; a locked VC owns the output until its last flit.
module noc_vc_rx_buffer #(
    parameter int VC_W      = 2,
    parameter int D_W       = 32,
    parameter int A_W       = 4,
    parameter int DEPTH     = 64,
    parameter int COUNTER_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [VC_W-1:0]           i_vc,
    input  logic [D_W-1:0]            i_data,
    input  logic                      i_last,
    input  logic [A_W-1:0]            i_addr,
    output logic [VC_W-1:0]           o_ready,
    output logic                      o_drop,
    output logic                      o_valid,
    output logic [VC_W-1:0]           o_vc,
    output logic [D_W-1:0]            o_data,
    output logic                      o_last,
    output logic [A_W-1:0]            o_addr,
    input  logic                      i_ready,
    output logic [VC_W*COUNTER_W-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam int ENT_W = D_W + A_W + 1;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    logic [ENT_W-1:0]               mem_q [VC_W][DEPTH];
    logic [VC_W-1:0][PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [VC_W-1:0][COUNTER_W-1:0] count_q, count_d;
    logic [VC_W-1:0]                ready_q;
    arb_state_e                     state_q;
    logic [IDX_W-1:0]               lock_q, rr_q;
    logic                           valid_q, last_q, drop_q;
    logic [VC_W-1:0]                vc_q;
    logic [D_W-1:0]                 data_q;
    logic [A_W-1:0]                 addr_q;

    logic                           vc_onehot, or_free, gnt_valid;
    logic [IDX_W-1:0]               gnt_idx, scan_idx;
    logic [VC_W-1:0]                nonempty, wr_en, rd_en;
    logic [ENT_W-1:0]               head;

    assign vc_onehot = $onehot(i_vc);
    assign or_free   = ~valid_q | i_ready;
    assign head      = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            nonempty[v] = (count_q[v] != '0);
            wr_en[v]    = i_valid & vc_onehot & i_vc[v] & ready_q[v];
        end
    end

    // Scan downwards so the VC closest after the RR pointer overrides the others.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        if (state_q == LOCKED) begin
            gnt_valid = nonempty[lock_q];
            gnt_idx   = lock_q;
        end else begin
            for (int k = VC_W; k >= 1; k--) begin
                scan_idx = IDX_W'((int'(rr_q) + k) % VC_W);
                if (nonempty[scan_idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            rd_en[v]   = or_free & gnt_valid & (gnt_idx == IDX_W'(v));
            count_d[v] = count_q[v];
            if (wr_en[v] && !rd_en[v]) begin
                count_d[v] = count_q[v] + 1'b1;
            end else if (!wr_en[v] && rd_en[v]) begin
                count_d[v] = count_q[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_W; v++) begin
            if (wr_en[v]) begin
                mem_q[v][wr_ptr_q[v]] <= {i_last, i_addr, i_data};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= '1;
            state_q  <= IDLE;
            lock_q   <= '0;
            rr_q     <= IDX_W'(VC_W - 1);
            valid_q  <= 1'b0;
            vc_q     <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            addr_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            for (int v = 0; v < VC_W; v++) begin
                if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
                if (rd_en[v]) rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
                ready_q[v] <= (count_d[v] != COUNTER_W'(DEPTH));
            end
            drop_q <= i_valid & ~vc_onehot;
            if (or_free) begin
                valid_q <= gnt_valid;
                if (gnt_valid) begin
                    vc_q                     <= VC_W'(1) << gnt_idx;
                    {last_q, addr_q, data_q} <= head;
                    rr_q                     <= gnt_idx;
                    lock_q                   <= gnt_idx;
                    state_q                  <= head[ENT_W-1] ? IDLE : LOCKED;
                end
            end
        end
    end

    assign o_ready = ready_q;
    assign o_drop  = drop_q;
    assign o_valid = valid_q;
    assign o_vc    = vc_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_addr  = addr_q;
    assign o_count = count_q;
endmodule

// File: tb/tb_noc_vc_rx_buffer.sv
// tb/tb_noc_vc_rx_buffer.sv - self-checking bench for noc_vc_rx_buffer
module tb_noc_vc_rx_buffer;
    localparam int VC_W  = 2;
    localparam int D_W   = 32;
    localparam int A_W   = 4;
    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_valid = 1'b0;
    logic [VC_W-1:0]      i_vc = '0;
    logic [D_W-1:0]       i_data = '0;
    logic                 i_last = 1'b0;
    logic [A_W-1:0]       i_addr = '0;
    logic                 i_ready = 1'b0;
    logic [VC_W-1:0]      o_ready;
    logic                 o_drop;
    logic                 o_valid;
    logic [VC_W-1:0]      o_vc;
    logic [D_W-1:0]       o_data;
    logic                 o_last;
    logic [A_W-1:0]       o_addr;
    logic [VC_W*CW-1:0]   o_count;

    noc_vc_rx_buffer #(.VC_W(VC_W), .D_W(D_W), .A_W(A_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_vc(i_vc), .i_data(i_data),
        .i_last(i_last), .i_addr(i_addr), .o_ready(o_ready), .o_drop(o_drop),
        .o_valid(o_valid), .o_vc(o_vc), .o_data(o_data), .o_last(o_last),
        .o_addr(o_addr), .i_ready(i_ready), .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VC_W-1:0] vc;
        logic            last;
        logic [A_W-1:0]  addr;
        logic [D_W-1:0]  data;
    } flit_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    flit_t store[$];
    flit_t out_log[$];
    flit_t m_out;
    logic  m_valid, m_drop, m_locked;
    int    m_lockv, m_rr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [VC_W-1:0] onehot(input int v);
        return VC_W'(1) << v;
    endfunction

    function automatic int occ(input int v);
        int n = 0;
        foreach (store[i]) if (store[i].vc == onehot(v)) n++;
        return n;
    endfunction

    function automatic flit_t take(input int v);
        flit_t f = '0;
        for (int i = 0; i < store.size(); i++) begin
            if (store[i].vc == onehot(v)) begin
                f = store[i];
                store.delete(i);
                break;
            end
        end
        return f;
    endfunction

    function automatic logic [VC_W-1:0] exp_ready();
        logic [VC_W-1:0] r;
        for (int v = 0; v < VC_W; v++) r[v] = (occ(v) != DEPTH);
        return r;
    endfunction

    function automatic logic [VC_W*CW-1:0] exp_count();
        logic [VC_W*CW-1:0] r;
        for (int v = 0; v < VC_W; v++) r[v*CW +: CW] = CW'(occ(v));
        return r;
    endfunction

    // Advances the model by the edge that will sample the inputs now on the pins.
    task automatic model_step();
        bit onehot_in;
        bit acc;
        int tgt;
        int src;
        onehot_in = ($countones(i_vc) == 1);
        tgt = 0;
        for (int v = 0; v < VC_W; v++) if (i_vc[v]) tgt = v;
        acc    = i_valid && onehot_in && (occ(tgt) != DEPTH);
        m_drop = i_valid && !onehot_in;
        if (!m_valid || i_ready) begin
            src = -1;
            if (m_locked) begin
                if (occ(m_lockv) > 0) src = m_lockv;
            end else begin
                for (int k = 1; k <= VC_W; k++)
                    if (src < 0 && occ((m_rr + k) % VC_W) > 0) src = (m_rr + k) % VC_W;
            end
            if (src >= 0) begin
                m_out    = take(src);
                m_valid  = 1'b1;
                m_rr     = src;
                m_locked = !m_out.last;
                m_lockv  = src;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (acc) store.push_back({i_vc, i_last, i_addr, i_data});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            store.delete();
            m_valid  = 1'b0;
            m_drop   = 1'b0;
            m_locked = 1'b0;
            m_lockv  = 0;
            m_rr     = VC_W - 1;
            m_out    = '0;
        end else begin
            chk("o_valid", 64'(o_valid), 64'(m_valid));
            chk("o_drop", 64'(o_drop), 64'(m_drop));
            chk("o_ready", 64'(o_ready), 64'(exp_ready()));
            chk("o_count", 64'(o_count), 64'(exp_count()));
            if (m_valid) chk("o_flit", 64'({o_vc, o_last, o_addr, o_data}), 64'(m_out));
            if (o_valid && i_ready) out_log.push_back({o_vc, o_last, o_addr, o_data});
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [VC_W-1:0] vc, input logic [D_W-1:0] d,
                       input logic l, input logic [A_W-1:0] a);
        i_valid = 1'b1; i_vc = vc; i_data = d; i_last = l; i_addr = a;
        tick();
        i_valid = 1'b0; i_vc = '0;
    endtask

    initial begin
        logic [3:0] a4;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_ready", 64'(o_ready), 64'h3);
        chk("rst_count", 64'(o_count), 64'h0);
        chk("rst_valid", 64'(o_valid), 64'h0);

        // single flit latency
        i_ready = 1'b1;
        put(2'b01, 32'hA5A5_0001, 1'b1, 4'h3);
        chk("t1_cnt_k", 64'(o_count[CW-1:0]), 64'd1);
        chk("t1_valid_k", 64'(o_valid), 64'h0);
        tick();
        chk("t1_valid_k1", 64'(o_valid), 64'h1);
        chk("t1_flit", 64'({o_vc, o_last, o_addr, o_data}), {25'h0, 2'b01, 1'b1, 4'h3, 32'hA5A5_0001});
        chk("t1_cnt_k1", 64'(o_count[CW-1:0]), 64'd0);
        tick();
        chk("t1_valid_k2", 64'(o_valid), 64'h0);

        // malformed VC drops
        i_valid = 1'b1; i_vc = 2'b11; i_data = 32'h1111_1111;
        tick();
        chk("drop_11", 64'(o_drop), 64'h1);
        i_vc = 2'b00;
        tick();
        chk("drop_00", 64'(o_drop), 64'h1);
        i_valid = 1'b0;
        tick();
        chk("drop_clear", 64'(o_drop), 64'h0);
        chk("drop_count", 64'(o_count), 64'h0);

        // fill VC1: one flit parks in the output register, DEPTH in the FIFO
        i_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            a4 = 4'(i);
            put(2'b10, 32'(32'h100 + i), 1'b1, a4);
        end
        chk("fill_ready", 64'(o_ready), 64'h1);
        chk("fill_count", 64'(o_count[2*CW-1:CW]), 64'd64);
        put(2'b10, 32'hDEAD_BEEF, 1'b1, 4'h0);
        chk("over_count", 64'(o_count[2*CW-1:CW]), 64'd64);
        chk("over_drop", 64'(o_drop), 64'h0);
        out_log.delete();
        i_ready = 1'b1;
        repeat (70) tick();
        chk("drain_len", 64'(out_log.size()), 64'd65);
        for (int i = 0; i < out_log.size(); i++)
            chk("drain_data", 64'(out_log[i].data), 64'(32'h100 + i));

        // packet atomicity with a VC0 stall while VC1 waits
        out_log.delete();
        put(2'b01, 32'hC000_0000, 1'b0, 4'h1);
        put(2'b10, 32'hB000_0000, 1'b1, 4'h2);
        chk("atom_first", 64'(o_data), 64'hC000_0000);
        tick();
        chk("atom_bubble", 64'(o_valid), 64'h0);
        chk("atom_vc1_cnt", 64'(o_count[2*CW-1:CW]), 64'd1);
        put(2'b01, 32'hC000_0001, 1'b0, 4'h1);
        put(2'b01, 32'hC000_0002, 1'b1, 4'h1);
        repeat (6) tick();
        chk("atom_len", 64'(out_log.size()), 64'd4);
        if (out_log.size() == 4) begin
            chk("atom_0", 64'({out_log[0].vc, out_log[0].data}), {30'h0, 2'b01, 32'hC000_0000});
            chk("atom_1", 64'({out_log[1].vc, out_log[1].data}), {30'h0, 2'b01, 32'hC000_0001});
            chk("atom_2", 64'({out_log[2].vc, out_log[2].data}), {30'h0, 2'b01, 32'hC000_0002});
            chk("atom_3", 64'({out_log[3].vc, out_log[3].data}), {30'h0, 2'b10, 32'hB000_0000});
        end

        // asynchronous reset mid-packet
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(2'b01, 32'(32'hD000_0000 + i), 1'b0, 4'h7);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(o_valid), 64'h0);
        chk("arst_count", 64'(o_count), 64'h0);
        chk("arst_ready", 64'(o_ready), 64'h3);
        tick();
        rst = 1'b0;

        // round robin over single-flit packets
        out_log.delete();
        for (int i = 0; i < 3; i++) begin
            put(2'b01, 32'(32'h0A00 + i), 1'b1, 4'h0);
            put(2'b10, 32'(32'h0B00 + i), 1'b1, 4'h0);
        end
        i_ready = 1'b1;
        repeat (10) tick();
        chk("rr_len", 64'(out_log.size()), 64'd6);
        if (out_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("rr_vc", 64'(out_log[i].vc), (i % 2 == 0) ? 64'h1 : 64'h2);
                chk("rr_data", 64'(out_log[i].data),
                    64'(((i % 2 == 0) ? 32'h0A00 : 32'h0B00) + 32'(i / 2)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
